// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch port, the load/store port and the shared memory.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and load/store.
// Data has priority; a starvation counter hands fetch the port after STARVE_MAX lost rounds.
module mem_port_arbiter_chk #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input logic clk
);
    a_mem_lat_range: assert property (@(posedge clk) (MEM_LAT >= 1) && (MEM_LAT <= 4));
    a_starve_range:  assert property (@(posedge clk) (STARVE_MAX >= 1) && (STARVE_MAX <= 15));
endmodule

module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_e;

    localparam logic [1:0] LAT_LAST   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [1:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              d_win_s, if_win_s, capture_s;

    mem_port_arbiter_chk #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) u_chk (.clk(clk));

    // Pick this cycle's winner; only an idle port can grant.
    always_comb begin
        d_win_s  = 1'b0;
        if_win_s = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.d_req && (starve_q < STARVE_LIM)) begin
                d_win_s = 1'b1;
            end else if (bus.if_req) begin
                if_win_s = 1'b1;
            end else if (bus.d_req) begin
                d_win_s = 1'b1;
            end else begin
                d_win_s = 1'b0;
            end
        end else begin
            if_win_s = 1'b0;
        end
    end

    // Next state, captured request fields, starvation tracking and read completion.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_win_s) begin
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    be_d    = bus.d_we ? bus.d_be : 4'hF;
                    if (!bus.d_we) begin
                        state_d = S_WAIT;
                        owner_d = OWN_D;
                        lat_d   = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (if_win_s) begin
                    addr_d  = bus.if_addr;
                    be_d    = 4'hF;
                    state_d = S_WAIT;
                    owner_d = OWN_IF;
                    lat_d   = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
                // Only a fetch that is actually waiting counts as starved.
                if (!bus.if_req || if_win_s) begin
                    starve_d = 4'd0;
                end else if (d_win_s && (starve_q < STARVE_LIM)) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
            end
            S_WAIT: begin
                if (!bus.if_req) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q;
                end
                if (lat_q == LAT_LAST) begin
                    capture_s = 1'b1;
                    state_d   = S_IDLE;
                    owner_d   = OWN_NONE;
                    lat_d     = 2'd0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                lat_d   = 2'd0;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            lat_q       <= 2'd0;
            starve_q    <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'h0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rvalid_q <= capture_s && (owner_q == OWN_IF);
            d_rvalid_q  <= capture_s && (owner_q == OWN_D);
            if (capture_s && (owner_q == OWN_IF)) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (capture_s && (owner_q == OWN_D)) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Grant and strobe paths are combinational so the memory sees the request in the grant cycle.
    assign bus.if_gnt    = reset & if_win_s;
    assign bus.d_gnt     = reset & d_win_s;
    assign bus.mem_en    = reset & (if_win_s | d_win_s);
    assign bus.mem_we    = reset & d_win_s & bus.d_we;
    assign bus.mem_addr  = addr_d;
    assign bus.mem_wdata = wdata_d;
    assign bus.mem_be    = be_d;
    assign bus.busy      = reset & (state_q == S_WAIT);
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule
